// File: rtl/box_grid.sv
// box_grid: COLS x ROWS destructible-box tile bitmap with pixel lookup, bomberman
// collision probing and a req/ack destroy port. Define BOX_COUNT_EN to add boxes_left.
module box_grid #(
  parameter int unsigned COLS      = 15,
  parameter int unsigned ROWS      = 11,
  parameter int unsigned TILE_LOG2 = 5,
  parameter int unsigned X0        = 48,
  parameter int unsigned Y0        = 32,
  parameter int unsigned SPRITE    = 16,
  parameter logic [11:0] BOX_RGB   = 12'hA52
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  input  logic        destroy_req,
  input  logic [4:0]  destroy_col,
  input  logic [3:0]  destroy_row,
  output logic        destroy_ack,
  output logic        box_on,
  output logic [11:0] rgb_out,
  output logic [3:0]  bomberman_blocked,
  output logic        blocked_valid,
  output logic        ready
`ifdef BOX_COUNT_EN
  ,
  output logic [7:0]  boxes_left
`endif
);

  localparam int unsigned N      = COLS * ROWS;
  localparam int unsigned IDX_W  = $clog2(N);
  localparam logic [10:0] X0_W   = 11'(X0);
  localparam logic [10:0] Y0_W   = 11'(Y0);
  localparam logic [10:0] COLS_W = 11'(COLS);
  localparam logic [10:0] ROWS_W = 11'(ROWS);
  localparam logic [10:0] SPR_W  = 11'(SPRITE);
  localparam logic [10:0] HALF_W = 11'(SPRITE / 32'd2);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PROBE   = 2'd2,
    ST_DESTROY = 2'd3
  } state_t;

  // Returns {valid, tile}; points are 11 bits wide so a 10-bit wrap shows up in bit 10.
  function automatic logic [8:0] map_axis(input logic [10:0] p, input logic [10:0] origin,
                                          input logic [10:0] limit);
    logic [10:0] t;
    t = (p - origin) >> TILE_LOG2;
    if (p[10] || (p < origin) || (t >= limit)) begin
      map_axis = 9'd0;
    end else begin
      map_axis = {1'b1, t[7:0]};
    end
  endfunction

  function automatic logic [IDX_W-1:0] lin_idx(input logic [7:0] col, input logic [7:0] row);
    lin_idx = IDX_W'(({8'd0, row} * 16'(COLS)) + {8'd0, col});
  endfunction

  state_t             state_r, state_nx_s;
  logic [N-1:0]       bitmap_r;
  logic [IDX_W-1:0]   init_idx_r;
  logic [7:0]         init_col_r, init_row_r;
  logic               ready_r;
  logic               init_last_s, probe_last_s, start_box_s;
  logic [1:0]         probe_dir_r;
  logic [3:1]         probe_acc_r;
  logic [3:0]         blocked_r;
  logic               blocked_valid_r;
  logic               destroy_ack_r;
  logic               box_on_r;
  logic [11:0]        rgb_r;
  logic [10:0]        bx_w_s, by_w_s, probe_px_s, probe_py_s;
  logic [8:0]         probe_cx_s, probe_ry_s, pix_cx_s, pix_ry_s;
  logic               probe_blk_s, pix_hit_s;
  logic               dest_in_range_s;
  logic [IDX_W-1:0]   dest_idx_s;

  assign bx_w_s = {1'b0, b_x};
  assign by_w_s = {1'b0, b_y};

  assign start_box_s = !((init_col_r[0] & init_row_r[0]) ||
                         ((init_row_r == 8'd0) && (init_col_r <= 8'd1)) ||
                         ((init_col_r == 8'd0) && (init_row_r == 8'd1)));

  assign dest_in_range_s = ({3'd0, destroy_col} < 8'(COLS)) && ({4'd0, destroy_row} < 8'(ROWS));
  assign dest_idx_s      = lin_idx({3'd0, destroy_col}, {4'd0, destroy_row});

  assign pix_cx_s  = map_axis({1'b0, v_x}, X0_W, COLS_W);
  assign pix_ry_s  = map_axis({1'b0, v_y}, Y0_W, ROWS_W);
  assign pix_hit_s = pix_cx_s[8] & pix_ry_s[8] & bitmap_r[lin_idx(pix_cx_s[7:0], pix_ry_s[7:0])];

  // Probe point for the direction currently being swept.
  always_comb begin
    probe_px_s = 11'd0;
    probe_py_s = 11'd0;
    case (probe_dir_r)
      2'd0: begin probe_px_s = bx_w_s + HALF_W; probe_py_s = by_w_s - 11'd1;  end
      2'd1: begin probe_px_s = bx_w_s + HALF_W; probe_py_s = by_w_s + SPR_W;  end
      2'd2: begin probe_px_s = bx_w_s - 11'd1;  probe_py_s = by_w_s + HALF_W; end
      2'd3: begin probe_px_s = bx_w_s + SPR_W;  probe_py_s = by_w_s + HALF_W; end
      default: begin probe_px_s = 11'd0; probe_py_s = 11'd0; end
    endcase
  end

  assign probe_cx_s  = map_axis(probe_px_s, X0_W, COLS_W);
  assign probe_ry_s  = map_axis(probe_py_s, Y0_W, ROWS_W);
  assign probe_blk_s = !(probe_cx_s[8] & probe_ry_s[8]) |
                       bitmap_r[lin_idx(probe_cx_s[7:0], probe_ry_s[7:0])];

  // Next-state decode; destroy wins over a new sweep only from IDLE.
  always_comb begin
    state_nx_s   = state_r;
    init_last_s  = 1'b0;
    probe_last_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (init_idx_r == IDX_W'(N - 1)) begin
          state_nx_s  = ST_IDLE;
          init_last_s = 1'b1;
        end else begin
          state_nx_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (destroy_req) begin
          state_nx_s = ST_DESTROY;
        end else begin
          state_nx_s = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (probe_dir_r == 2'd3) begin
          state_nx_s   = ST_IDLE;
          probe_last_s = 1'b1;
        end else begin
          state_nx_s = ST_PROBE;
        end
      end
      ST_DESTROY: state_nx_s = ST_IDLE;
      default:    state_nx_s = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Bitmap: layout load in INIT, single-bit clear in DESTROY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitmap_r   <= {N{1'b0}};
      init_idx_r <= {IDX_W{1'b0}};
      init_col_r <= 8'd0;
      init_row_r <= 8'd0;
      ready_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          bitmap_r[init_idx_r] <= start_box_s;
          init_idx_r           <= init_idx_r + 1'b1;
          ready_r              <= init_last_s;
          if (init_col_r == 8'(COLS - 1)) begin
            init_col_r <= 8'd0;
            init_row_r <= init_row_r + 8'd1;
          end else begin
            init_col_r <= init_col_r + 8'd1;
          end
        end
        ST_DESTROY: begin
          if (dest_in_range_s) begin
            bitmap_r[dest_idx_s] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sweep: gather up/down/left, publish all four bits together with right.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      probe_dir_r     <= 2'd0;
      probe_acc_r     <= 3'd0;
      blocked_r       <= 4'd0;
      blocked_valid_r <= 1'b0;
    end else begin
      blocked_valid_r <= 1'b0;
      if (state_r == ST_PROBE) begin
        probe_dir_r <= probe_dir_r + 2'd1;
        if (probe_last_s) begin
          blocked_r       <= {probe_acc_r, probe_blk_s};
          blocked_valid_r <= 1'b1;
        end else begin
          probe_acc_r[2'd3 - probe_dir_r] <= probe_blk_s;
        end
      end else begin
        probe_dir_r <= 2'd0;
      end
    end
  end

  // Ack follows the DESTROY cycle; pixel outputs are gated until the layout is in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      destroy_ack_r <= 1'b0;
      box_on_r      <= 1'b0;
      rgb_r         <= 12'h000;
    end else begin
      destroy_ack_r <= (state_r == ST_DESTROY);
      box_on_r      <= ready_r & pix_hit_s;
      rgb_r         <= (ready_r & pix_hit_s) ? BOX_RGB : 12'h000;
    end
  end

`ifdef BOX_COUNT_EN
  logic [7:0] boxes_left_r;
  logic       dest_occ_s;

  assign dest_occ_s = dest_in_range_s & bitmap_r[dest_idx_s];

  // Live box count: built during INIT, decremented only for occupied tiles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      boxes_left_r <= 8'd0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (start_box_s) begin
            boxes_left_r <= boxes_left_r + 8'd1;
          end
        end
        ST_DESTROY: begin
          if (dest_occ_s && (boxes_left_r != 8'd0)) begin
            boxes_left_r <= boxes_left_r - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign boxes_left = boxes_left_r;
`endif

  assign destroy_ack       = destroy_ack_r;
  assign box_on            = box_on_r;
  assign rgb_out           = rgb_r;
  assign bomberman_blocked = blocked_r;
  assign blocked_valid     = blocked_valid_r;
  assign ready             = ready_r;

endmodule

// File: tb/tb_box_grid.sv
// Scoreboard bench for box_grid with default parameters; expectations come from a
// behavioural grid model. Define BOX_COUNT_EN to also check boxes_left.
module tb_box_grid;

  localparam int X0 = 48, Y0 = 32, TILE = 32, NC = 15, NR = 11, SPR = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  b_x = 10'd0, b_y = 10'd0, v_x = 10'd0, v_y = 10'd0;
  logic        destroy_req = 1'b0;
  logic [4:0]  destroy_col = 5'd0;
  logic [3:0]  destroy_row = 4'd0;
  logic        destroy_ack, box_on, blocked_valid, ready;
  logic [11:0] rgb_out;
  logic [3:0]  bomberman_blocked;
`ifdef BOX_COUNT_EN
  logic [7:0]  boxes_left;
`endif

  int total = 0;
  int bad = 0;
  bit cleared [0:NC*NR-1];
  logic [3:0]  blk_q [$];
  logic [12:0] pix_q [$];

  box_grid dut (
    .clk(clk), .reset(reset), .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
    .destroy_req(destroy_req), .destroy_col(destroy_col), .destroy_row(destroy_row),
    .destroy_ack(destroy_ack), .box_on(box_on), .rgb_out(rgb_out),
    .bomberman_blocked(bomberman_blocked), .blocked_valid(blocked_valid), .ready(ready)
`ifdef BOX_COUNT_EN
    , .boxes_left(boxes_left)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit layout(int c, int r);
    return !(((c % 2) == 1 && (r % 2) == 1) || (c == 0 && r == 0) ||
             (c == 1 && r == 0) || (c == 0 && r == 1));
  endfunction

  function automatic bit model_box(int c, int r);
    if (c < 0 || c >= NC || r < 0 || r >= NR) return 1'b0;
    return layout(c, r) && !cleared[r*NC + c];
  endfunction

  function automatic int tile_of(int p, int origin);
    if (p < origin) return -1;
    return (p - origin) / TILE;
  endfunction

  function automatic bit point_blocked(int px, int py);
    int c, r;
    c = tile_of(px, X0);
    r = tile_of(py, Y0);
    if (c < 0 || c >= NC || r < 0 || r >= NR) return 1'b1;
    return model_box(c, r);
  endfunction

  function automatic logic [3:0] model_blocked(int bx, int by);
    return {point_blocked(bx + SPR/2, by - 1), point_blocked(bx + SPR/2, by + SPR),
            point_blocked(bx - 1, by + SPR/2), point_blocked(bx + SPR, by + SPR/2)};
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (model_box(c, r)) n++;
    return n;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (blocked_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready(output int n, output bit saw_box, output bit saw_ack);
    n = 0; saw_box = 1'b0; saw_ack = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (box_on) saw_box = 1'b1;
      if (destroy_ack) saw_ack = 1'b1;
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pix(input string tag, input int x, input int y);
    logic [12:0] e;
    bit b;
    @(negedge clk);
    v_x = 10'(x);
    v_y = 10'(y);
    b = (tile_of(x, X0) >= 0) && (tile_of(y, Y0) >= 0) && model_box(tile_of(x, X0), tile_of(y, Y0));
    pix_q.push_back({b, b ? 12'hA52 : 12'h000});
    @(negedge clk);
    e = pix_q.pop_front();
    chk_eq({tag, "_box_on"}, box_on, e[12]);
    chk_eq({tag, "_rgb"}, rgb_out, e[11:0]);
  endtask

  task automatic blocked_at(input string tag, input int bx, input int by);
    bit got;
    b_x = 10'(bx);
    b_y = 10'(by);
    blk_q.push_back(model_blocked(bx, by));
    wait_valid(got);
    wait_valid(got);
    chk_eq({tag, "_seen"}, got, 1);
    chk_eq(tag, bomberman_blocked, blk_q.pop_front());
  endtask

  task automatic do_destroy(input string tag, input int c, input int r, input int exp_lat);
    int lat;
    bit got;
    wait_valid(got);
    destroy_col = 5'(c);
    destroy_row = 4'(r);
    destroy_req = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (destroy_ack) begin
        lat = i;
        destroy_req = 1'b0;
        break;
      end
    end
    destroy_req = 1'b0;
    if (c < NC && r < NR) cleared[r*NC + c] = 1'b1;
    chk_eq({tag, "_ack_lat"}, lat, exp_lat);
    tick();
    chk_eq({tag, "_ack_pulse"}, destroy_ack, 0);
  endtask

  initial begin
    int n, vat, aat;
    bit sb, sa, got;
    logic [3:0] vblk;

    v_x = 10'(X0 + 64);
    v_y = 10'(Y0);
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_ready", ready, 0);
    chk_eq("rst_box_on", box_on, 0);
    chk_eq("rst_rgb", rgb_out, 0);
    chk_eq("rst_blocked", bomberman_blocked, 0);
    chk_eq("rst_valid", blocked_valid, 0);
    chk_eq("rst_ack", destroy_ack, 0);
`ifdef BOX_COUNT_EN
    chk_eq("rst_count", boxes_left, 0);
`endif
    reset = 1'b1;
    wait_ready(n, sb, sa);
    chk_eq("ready_lat", n, 165);
    chk_eq("init_box_gated", sb, 0);

    pix("t2_0", X0 + 64, Y0);
    pix("pillar1_1", X0 + 32, Y0 + 32);
    pix("spawn0_0", X0, Y0);
    pix("spawn0_1", X0 + 5, Y0 + 40);
    pix("left_off", X0 - 1, Y0);
    pix("corner14_10", X0 + 14*TILE + 31, Y0 + 10*TILE + 31);
    pix("col_off", X0 + 15*TILE, Y0);
    pix("row_off", X0 + 64, Y0 + 11*TILE);
`ifdef BOX_COUNT_EN
    chk_eq("count_init", boxes_left, model_count());
`endif

    wait_valid(got);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) chk_eq("valid_pulse", blocked_valid, 0);
      if (blocked_valid) begin
        n = i;
        break;
      end
    end
    chk_eq("cadence", n, 5);

    blocked_at("blk_origin", X0, Y0);
    blocked_at("blk_zero", 0, 0);
    blocked_at("blk_tile1_0", X0 + 40, Y0 + 8);
    blocked_at("blk_bottom", X0 + 14*TILE + 16, Y0 + 10*TILE + 16);
    blocked_at("blk_near2_0", X0 + 48, Y0);

    do_destroy("d2_0", 2, 0, 2);
    pix("d2_0_px", X0 + 64, Y0 + 3);
`ifdef BOX_COUNT_EN
    chk_eq("count_d1", boxes_left, model_count());
`endif
    blocked_at("blk_after", X0 + 48, Y0);
    do_destroy("d2_0_again", 2, 0, 2);
    pix("d2_0_again_px", X0 + 64, Y0);
    do_destroy("d_oor", 20, 3, 2);
    pix("t4_3", X0 + 4*TILE, Y0 + 3*TILE);
`ifdef BOX_COUNT_EN
    chk_eq("count_d3", boxes_left, model_count());
`endif

    // Request arrives in the first probe cycle of a sweep.
    wait_valid(got);
    tick();
    blk_q.push_back(model_blocked(X0 + 48, Y0));
    destroy_col = 5'd4;
    destroy_row = 4'd0;
    destroy_req = 1'b1;
    vat = -1; aat = -1; vblk = 4'd0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (blocked_valid) begin
        vat = i;
        vblk = bomberman_blocked;
      end
      if (destroy_ack) begin
        aat = i;
        destroy_req = 1'b0;
        break;
      end
    end
    destroy_req = 1'b0;
    cleared[4] = 1'b1;
    chk_eq("mid_valid_at", vat, 4);
    chk_eq("mid_blocked", vblk, blk_q.pop_front());
    chk_eq("mid_ack_at", aat, 6);
    pix("t4_0_px", X0 + 4*TILE + 7, Y0 + 9);

    // Reset pulse while a destroy sits in the DESTROY state.
    wait_valid(got);
    destroy_col = 5'd6;
    destroy_row = 4'd0;
    destroy_req = 1'b1;
    tick();
    reset = 1'b0;
    destroy_req = 1'b0;
    tick();
    chk_eq("rst_mid_ack", destroy_ack, 0);
    chk_eq("rst_mid_ready", ready, 0);
    reset = 1'b1;
    for (int i = 0; i < NC*NR; i++) cleared[i] = 1'b0;
    wait_ready(n, sb, sa);
    chk_eq("reload_lat", n, 165);
    chk_eq("reload_no_ack", sa, 0);
    chk_eq("reload_box_gated", sb, 0);
    pix("t2_0_restored", X0 + 64, Y0);
    pix("t6_0_kept", X0 + 6*TILE, Y0);
`ifdef BOX_COUNT_EN
    chk_eq("count_reload", boxes_left, model_count());
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
